// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin binary-index arbiter.
// Default sizing matches the 15-requester, 4-bit-index configuration.
package arb_pkg;
  localparam int NREQ_DEF  = 15;
  localparam int IDX_W_DEF = 4;

  typedef logic [IDX_W_DEF-1:0] arb_idx_t;
  typedef logic [NREQ_DEF-1:0]  arb_req_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
// Finds the first set request at or above ptr, wrapping from NREQ-1 back
// to 0. The request vector is concatenated with itself, and bits below ptr
// are masked out. The lowest surviving bit is the winner. Any bit in the
// upper copy lies at or above ptr, so it is never masked, and a request
// anywhere is always found.
// Ports:
//   req   in  NREQ   level requests
//   ptr   in  IDX_W  search start (0..NREQ-1)
//   found out 1      at least one request present
//   idx   out IDX_W  winner index (valid when found)
module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int j = 0; j < 2*NREQ; j++)
      masked[j] = dbl[j] && (j >= int'(ptr));
  end

  // Descending scan, so the lowest set position is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = 2*NREQ-1; j >= 0; j--) begin
      if (masked[j]) begin
        found = 1'b1;
        idx   = (j >= NREQ) ? IDX_W'(j - NREQ) : IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/arb_rr_bin_idx.sv
// arb_rr_bin_idx: round-robin arbiter with a registered binary winner index
// and a valid/ready handshake toward the binary-to-one-hot decode stage.
// The index holds stable under backpressure. IDLE and HOLD are the two
// states, and they are simply gnt_valid_q = 0 and gnt_valid_q = 1.
// Optional macro ARB_RR_LOCK_EN adds a 'lock' input. While lock is set, the
// current winner is re-granted and the pointer stays put, so a multi-beat
// burst is not interrupted.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   req       in  NREQ   level requests
//   gnt_ready in  1      downstream accepts gnt_idx
//   lock      in  1      (ARB_RR_LOCK_EN only) keep the current winner
//   gnt_valid out 1      gnt_idx is a valid winner
//   gnt_idx   out IDX_W  winner index, 0..NREQ-1
module arb_rr_bin_idx
  import arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             gnt_ready,
`ifdef ARB_RR_LOCK_EN
  input  logic             lock,
`endif
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_nxt, ptr_srch, pick_idx;
  logic             pick_found, xfer, lock_hit;

  always_comb begin
    xfer     = gnt_valid_q && gnt_ready;
    idx_nxt  = (gnt_idx_q == IDX_W'(NREQ-1)) ? '0 : gnt_idx_q + 1'b1;
    // The search for the next winner starts at the post-transfer pointer.
    // Because of this, a back-to-back grant already skips the requester
    // that just won.
    ptr_srch = xfer ? idx_nxt : ptr_q;
`ifdef ARB_RR_LOCK_EN
    lock_hit = xfer && lock && req[gnt_idx_q];
`else
    lock_hit = 1'b0;
`endif
  end

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (ptr_srch),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    if (!gnt_valid_q || xfer) begin
      if (lock_hit) begin
        gnt_valid_d = 1'b1;            // same index again, pointer frozen
      end else begin
        ptr_d       = ptr_srch;        // only moves when xfer is set
        gnt_valid_d = pick_found;
        if (pick_found) gnt_idx_d = pick_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
endmodule

// File: tb/tb_arb_rr_bin_idx.sv
module tb_arb_rr_bin_idx;
  localparam int NREQ  = 15;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic             gnt_ready;
  logic             lock;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  always #5 clk = ~clk;

  arb_rr_bin_idx #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
`ifdef ARB_RR_LOCK_EN
    .lock      (lock),
`endif
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always @(negedge clk)
    assert (int'(gnt_idx) < NREQ) else $error("gnt_idx out of range: %0d", gnt_idx);

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] req;
    logic            rdy;
    logic            lck;
    logic            ev;
    int              ei;
    string           nm;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural reference: plain integer state, modulo-NREQ scan
  int   m_valid, m_idx, m_ptr;

  function automatic void add(input string nm, input logic r, input logic [NREQ-1:0] q,
                              input logic rd, input logic lk, input logic ev, input int ei);
    vec_t v;
    v.nm = nm; v.rst = r; v.req = q; v.rdy = rd; v.lck = lk; v.ev = ev; v.ei = ei;
    tbl.push_back(v);
  endfunction

  task automatic model_step(input logic r, input logic [NREQ-1:0] q, input logic rd, input logic lk);
    int xfer, p, found, lock_en;
    lock_en = 0;
`ifdef ARB_RR_LOCK_EN
    lock_en = 1;
`endif
    if (r) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else begin
      xfer = m_valid && rd;
      if (!m_valid || xfer) begin
        if (xfer && lock_en && lk && q[m_idx]) begin
          m_valid = 1;
        end else begin
          p = xfer ? (m_idx + 1) % NREQ : m_ptr;
          if (xfer) m_ptr = p;
          found = 0;
          for (int off = 0; off < NREQ; off++)
            if (!found && q[(p + off) % NREQ]) begin
              found = 1; m_idx = (p + off) % NREQ;
            end
          m_valid = found;
        end
      end
    end
  endtask

  task automatic drive_clock(input logic r, input logic [NREQ-1:0] q, input logic rd, input logic lk);
    @(negedge clk);
    rst = r; req = q; gnt_ready = rd; lock = lk;
    @(posedge clk);
    model_step(r, q, rd, lk);
    #1;
  endtask

  task automatic check(input string nm, input logic ev, input int ei);
    n_vec++;
    if (gnt_valid !== ev || int'(gnt_idx) != ei) begin
      n_err++;
      $display("FAIL %s: got valid=%0b idx=%0d, want valid=%0b idx=%0d",
               nm, gnt_valid, gnt_idx, ev, ei);
    end
  endtask

  initial begin
    logic [NREQ-1:0] cur;
    logic            r, rd, lk;
    rst = 1'b1; req = '0; gnt_ready = 1'b0; lock = 1'b0;
    m_valid = 0; m_idx = 0; m_ptr = 0;

    // reset then idle
    add("rst0", 1, 15'h0000, 1, 0, 0, 0);
    add("rst1", 1, 15'h0000, 1, 0, 0, 0);
    add("idle0", 0, 15'h0000, 1, 0, 0, 0);
    add("idle1", 0, 15'h0000, 1, 0, 0, 0);
    // single requester re-granted every cycle
    add("single0", 0, 15'h0008, 1, 0, 1, 3);
    add("single1", 0, 15'h0008, 1, 0, 1, 3);
    add("single2", 0, 15'h0008, 1, 0, 1, 3);
    add("single_drop", 0, 15'h0000, 1, 0, 0, 3);
    add("single_idle", 0, 15'h0000, 1, 0, 0, 3);
    // fairness
    add("fair_rst", 1, 15'h0000, 1, 0, 0, 0);
    add("fair0", 0, 15'h0085, 1, 0, 1, 0);
    add("fair1", 0, 15'h0085, 1, 0, 1, 2);
    add("fair2", 0, 15'h0085, 1, 0, 1, 7);
    add("fair3", 0, 15'h0085, 1, 0, 1, 0);
    add("fair4", 0, 15'h0085, 1, 0, 1, 2);
    add("fair5", 0, 15'h0085, 1, 0, 1, 7);
    // backpressure
    add("bp_rst", 1, 15'h0000, 1, 0, 0, 0);
    add("bp0", 0, 15'h0060, 0, 0, 1, 5);
    add("bp1", 0, 15'h0060, 0, 0, 1, 5);
    add("bp2", 0, 15'h0060, 0, 0, 1, 5);
    add("bp_drop", 0, 15'h0040, 0, 0, 1, 5);
    add("bp_accept", 0, 15'h0040, 1, 0, 1, 6);
    add("bp_empty", 0, 15'h0000, 1, 0, 0, 6);
    // wrap-around
    add("wrap_rst", 1, 15'h0000, 1, 0, 0, 0);
    add("wrap13", 0, 15'h2000, 0, 0, 1, 13);
    add("wrap14", 0, 15'h4002, 1, 0, 1, 14);
    add("wrap1", 0, 15'h4002, 1, 0, 1, 1);
    // reset mid-operation, pointer must return to 0
    add("mid0", 0, 15'h0060, 1, 0, 1, 5);
    add("mid1", 0, 15'h0060, 1, 0, 1, 6);
    add("mid_hold", 0, 15'h0060, 0, 0, 1, 6);
    add("mid_rst", 1, 15'h0060, 0, 0, 0, 0);
    add("mid_ptr0", 0, 15'h0041, 1, 0, 1, 0);
`ifdef ARB_RR_LOCK_EN
    add("lock_rst", 1, 15'h0000, 1, 0, 0, 0);
    add("lock0", 0, 15'h0204, 1, 1, 1, 2);
    add("lock1", 0, 15'h0204, 1, 1, 1, 2);
    add("lock2", 0, 15'h0204, 1, 1, 1, 2);
    add("unlock", 0, 15'h0204, 1, 0, 1, 9);
    add("lock_noreq", 0, 15'h0004, 1, 1, 1, 2);
`endif

    foreach (tbl[k]) begin
      drive_clock(tbl[k].rst, tbl[k].req, tbl[k].rdy, tbl[k].lck);
      check(tbl[k].nm, tbl[k].ev, tbl[k].ei);
    end

    // randomized phase against the reference model
    drive_clock(1, '0, 0, 0);
    cur = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) cur = NREQ'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 99) == 0);
      lk = ($urandom_range(0, 2) == 0);
      drive_clock(r, cur, rd, lk);
      check("random", m_valid[0], m_idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
